duc_bank_core_tx_pack: RTL and testbench

//  Transmit-side counterpart of the DDC bank unpack/read interface. Accepts baseband I/Q for two

---
 rtl/duc_bank_core_tx_pack.sv | 139 +++++++++++++
 tb/tb_duc_bank_core_tx_pack.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/duc_bank_core_tx_pack.sv
// rtl/duc_bank_core_tx_pack.sv - TX I/Q gain/saturate/pack stage into the DAC sample FIFO.
// Optional underrun bubble counter built only when TX_UNDERRUN_CNT_EN is defined.
module duc_bank_core_tx_pack #(
    parameter int IQ_DATA_WIDTH        = 16,
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int DAC_PACK_DATA_WIDTH  = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0] cfg0,
    input  logic [IQ_DATA_WIDTH-1:0]        bw20_i0,
    input  logic [IQ_DATA_WIDTH-1:0]        bw20_q0,
    input  logic [IQ_DATA_WIDTH-1:0]        bw20_i1,
    input  logic [IQ_DATA_WIDTH-1:0]        bw20_q1,
    input  logic                            bw20_tvalid,
    output logic                            bw20_tready,
    input  logic                            iq_full_n,
    output logic [DAC_PACK_DATA_WIDTH-1:0]  iq_wr_data,
    output logic                            iq_wr_en,
    output logic                            tx_busy,
    output logic [15:0]                     underrun_cnt
);

    localparam int W  = IQ_DATA_WIDTH;
    localparam int EW = IQ_DATA_WIDTH + 4;
    localparam logic signed [EW-1:0] SAT_MAX = EW'(2 ** (W - 1) - 1);
    localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                         state;
    state_t                         state_nxt;
    logic                           go_run;
    logic [2:0]                     gain;
    logic                           v1;
    logic                           v2;
    logic                           ld1;
    logic                           ld2;
    logic [DAC_PACK_DATA_WIDTH-1:0] s1_data;
    logic                           cfg_unused;

    assign cfg_unused = ^cfg0[C_S00_AXI_DATA_WIDTH-1:4];

    // Four guard bits cover the largest shift (4), so the compare never wraps.
    function automatic logic [W-1:0] scale_sat(input logic [W-1:0] x, input logic [2:0] g);
        logic signed [EW-1:0] sh;
        sh = $signed({{4{x[W-1]}}, x}) <<< g;
        if (sh > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (sh < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return sh[W-1:0];
    endfunction

    always_comb begin
        state_nxt = state;
        go_run    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg0[0]) begin
                    state_nxt = S_RUN;
                    go_run    = 1'b1;
                end
            end
            S_RUN: begin
                if (!cfg0[0])
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (cfg0[0])
                    state_nxt = S_RUN;
                else if (!v1 && !v2)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ld2         = v1 & (~v2 | iq_full_n);
    assign bw20_tready = (state == S_RUN) & (~v1 | ld2);
    assign ld1         = bw20_tvalid & bw20_tready;
    assign iq_wr_en    = v2 & iq_full_n;
    assign tx_busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            gain       <= 3'd0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            s1_data    <= '0;
            iq_wr_data <= '0;
        end else begin
            state <= state_nxt;
            if (go_run)
                gain <= (cfg0[3:1] > 3'd4) ? 3'd4 : cfg0[3:1];
            if (ld1) begin
                v1      <= 1'b1;
                s1_data <= {scale_sat(bw20_q1, gain), scale_sat(bw20_i1, gain),
                            scale_sat(bw20_q0, gain), scale_sat(bw20_i0, gain)};
            end else if (ld2) begin
                v1 <= 1'b0;
            end
            if (ld2) begin
                v2         <= 1'b1;
                iq_wr_data <= s1_data;
            end else if (iq_wr_en) begin
                v2 <= 1'b0;
            end
        end
    end

`ifdef TX_UNDERRUN_CNT_EN
    logic        first_wr_seen;
    logic [15:0] ucnt;

    always_ff @(posedge clk) begin
        if (rst || go_run) begin
            first_wr_seen <= 1'b0;
            ucnt          <= 16'd0;
        end else begin
            if (iq_wr_en)
                first_wr_seen <= 1'b1;
            if ((state == S_RUN) && first_wr_seen && iq_full_n && !v2 && (ucnt != 16'hFFFF))
                ucnt <= ucnt + 16'd1;
        end
    end

    assign underrun_cnt = ucnt;
`else
    assign underrun_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_duc_bank_core_tx_pack.sv
// tb/tb_duc_bank_core_tx_pack.sv - Randomized and directed bench with a queue-based reference model.
module tb_duc_bank_core_tx_pack;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg0;
    logic [15:0] i0, q0, i1, q1;
    logic        tvalid, tready, full_n;
    logic [63:0] wr_data;
    logic        wr_en, busy;
    logic [15:0] ucnt;

    always #5 clk = ~clk;

    duc_bank_core_tx_pack #(
        .IQ_DATA_WIDTH(16),
        .C_S00_AXI_DATA_WIDTH(32),
        .DAC_PACK_DATA_WIDTH(64)
    ) dut (
        .clk(clk), .rst(rst), .cfg0(cfg0),
        .bw20_i0(i0), .bw20_q0(q0), .bw20_i1(i1), .bw20_q1(q1),
        .bw20_tvalid(tvalid), .bw20_tready(tready), .iq_full_n(full_n),
        .iq_wr_data(wr_data), .iq_wr_en(wr_en), .tx_busy(busy), .underrun_cnt(ucnt)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          m_gain = 0;
    logic [63:0] exp_q[$];
    logic [63:0] wr_log[$];
    int          acc_cyc[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_scale(input logic [15:0] x, input int g);
        int v;
        v = int'($signed(x)) * (1 << g);
        if (v > 32767) v = 32767;
        else if (v < -32768) v = -32768;
        return 16'(v);
    endfunction

    // Reference model: every accepted set becomes one expected word, written in order.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (tvalid && tready) begin
                exp_q.push_back({m_scale(q1, m_gain), m_scale(i1, m_gain),
                                 m_scale(q0, m_gain), m_scale(i0, m_gain)});
                acc_cyc.push_back(cyc);
            end
            if (wr_en) begin
                chk("wr_while_full", full_n, 1'b1);
                chk("wr_while_idle", busy, 1'b1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=0x%0h required=no_write", wr_data);
                end else begin
                    chk("wr_data", wr_data, exp_q.pop_front());
                end
                wr_log.push_back(wr_data);
                wr_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic start_burst(input int g);
        wait_idle();
        cfg0   = {28'h0, 3'(g), 1'b1};
        m_gain = (g > 4) ? 4 : g;
        tick();
    endtask

    task automatic stop_burst;
        tvalid  = 1'b0;
        full_n  = 1'b1;
        cfg0[0] = 1'b0;
        wait_idle();
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
        bit hs = 0;
        int n  = 0;
        i0 = a; q0 = b; i1 = c; q1 = d;
        tvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = tvalid && tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=no_accept required=accept");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1; cfg0 = 32'h0; tvalid = 1'b0; full_n = 1'b1;
        i0 = '0; q0 = '0; i1 = '0; q1 = '0;
        repeat (3) tick();
        chk("rst_tready", tready, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_wr_data", wr_data, 64'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ucnt", ucnt, 16'h0);
        rst = 1'b0;
        tick();

        // Back-to-back sets at g=0: exact packing, latency 2, tready held high.
        start_burst(0);
        for (int k = 1; k <= 4; k++) begin
            i0 = 16'(k); q0 = 16'(16'h10 + k); i1 = 16'(16'h20 + k); q1 = 16'(16'h30 + k);
            tvalid = 1'b1;
            @(negedge clk);
            chk("b2b_tready", tready, 1'b1);
            tick();
        end
        tvalid = 1'b0;
        repeat (4) tick();
        chk("b2b_count", wr_log.size(), 4);
        if (wr_log.size() >= 4) begin
            for (int k = 0; k < 4; k++)
                chk("b2b_word", wr_log[k], 64'h0030_0020_0010_0000 + 64'h0001_0001_0001_0001 * (k + 1));
            chk("b2b_latency", wr_cyc[0] - acc_cyc[0], 2);
            chk("b2b_throughput", wr_cyc[3] - wr_cyc[0], 3);
        end
        stop_burst();

        // Saturation at g=1 and the clamped shift 7 -> 4.
        start_burst(1);
        send(16'h4000, 16'hC000, 16'h3FFF, 16'h8001);
        tvalid = 1'b0;
        repeat (4) tick();
        chk("sat_g1", wr_log[$], 64'h8000_7FFE_8000_7FFF);
        stop_burst();
        start_burst(7);
        send(16'h0100, 16'h0800, 16'hFFFF, 16'hF000);
        tvalid = 1'b0;
        repeat (4) tick();
        chk("sat_g7", wr_log[$], 64'h8000_FFF0_7FFF_1000);
        stop_burst();

        // Backpressure: FIFO full for 5 cycles in the middle of 10 sets.
        start_burst($urandom_range(0, 7));
        base = wr_log.size();
        fork
            begin
                for (int k = 0; k < 10; k++)
                    send(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                tvalid = 1'b0;
            end
            begin
                repeat (3) tick();
                full_n = 1'b0;
                repeat (4) tick();
                @(negedge clk);
                chk("bp_tready_low", tready, 1'b0);
                @(posedge clk);
                #1;
                full_n = 1'b1;
            end
        join
        repeat (4) tick();
        chk("bp_writes", wr_log.size() - base, 10);
        stop_burst();

        // Drain with two sets in flight.
        start_burst(0);
        base = wr_log.size();
        send(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        send(16'h0055, 16'h0066, 16'h0077, 16'h0088);
        tvalid  = 1'b0;
        cfg0[0] = 1'b0;
        wait_idle();
        chk("drain_writes", wr_log.size() - base, 2);
        chk("drain_busy", busy, 1'b0);
        tick();
        chk("drain_wr_en", wr_en, 1'b0);

        // Gain change mid-burst is ignored.
        start_burst(0);
        send(16'h0001, 16'h0002, 16'h0003, 16'h0004);
        cfg0[3:1] = 3'd3;
        send(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        tvalid = 1'b0;
        repeat (4) tick();
        chk("gain_held", wr_log[$], 64'h0400_0300_0200_0100);
        stop_burst();

        // Underrun: seven bubbles after the first write.
        start_burst(0);
        send(16'h1234, 16'h2345, 16'h3456, 16'h4567);
        tvalid = 1'b0;
        for (int n = 0; n < 10 && !wr_en; n++) @(negedge clk);
        repeat (8) @(posedge clk);
        #1;
`ifdef TX_UNDERRUN_CNT_EN
        chk("underrun_cnt", ucnt, 16'd7);
`else
        chk("underrun_cnt", ucnt, 16'd0);
`endif
        stop_burst();

        // Reset mid-burst with both stages full.
        start_burst(0);
        full_n = 1'b0;
        i0 = 16'hAAAA; q0 = 16'hBBBB; i1 = 16'hCCCC; q1 = 16'hDDDD;
        tvalid = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        cfg0 = 32'h0;
        tick();
        chk("mrst_wr_en", wr_en, 1'b0);
        chk("mrst_tready", tready, 1'b0);
        chk("mrst_wr_data", wr_data, 64'h0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_ucnt", ucnt, 16'h0);
        tvalid = 1'b0;
        full_n = 1'b1;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("mrst_no_stale", wr_en, 1'b0);
            tick();
        end

        // Randomized bursts with random valid, FIFO-full and gain pokes.
        for (int b = 0; b < 6; b++) begin
            start_burst($urandom_range(0, 7));
            repeat (80) begin
                tvalid = ($urandom_range(0, 3) != 0);
                i0 = 16'($urandom); q0 = 16'($urandom); i1 = 16'($urandom); q1 = 16'($urandom);
                full_n = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 15) == 0) cfg0[3:1] = 3'($urandom);
                tick();
            end
            stop_burst();
        end

        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
